// File: rtl/warp_pkg.sv
// Shared widths, the issue bundle carried through the output stage, and the
// operand-select helper used by operand_fetch.
package warp_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CTRL_W     = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic [CTRL_W-1:0]     ctrl;
    } issue_bundle_t;

    // Priority: unused or R0 reads as zero, then same-cycle writeback, then RF.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  used,
        input logic [XLEN-1:0]       rf_data,
        input logic                  wb_valid,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_data
    );
        logic [XLEN-1:0] result;
        result = rf_data;
        if (!used || rs == '0) begin
            result = '0;
        end else if (wb_valid && wb_rd == rs) begin
            result = wb_data;
        end
        return result;
    endfunction

endpackage

// File: rtl/warp_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// hazard lookups that already account for a writeback landing this cycle.
module warp_scoreboard #(
    parameter int NUM_REGS   = warp_pkg::NUM_REGS,
    parameter int REG_ADDR_W = warp_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic                  fclr_en,
    input  logic [REG_ADDR_W-1:0] fclr_idx,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic                  rs1_used,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_we,
    output logic                  haz1,
    output logic                  haz2,
    output logic                  hazw,
    output logic [NUM_REGS-1:0]   busy_mask
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // A register being written back this cycle no longer blocks anyone.
    function automatic logic lookup(
        input logic [REG_ADDR_W-1:0] idx,
        input logic                  used
    );
        return used && (idx != '0) && busy_reg[idx] && !(clr_en && clr_idx == idx);
    endfunction

    assign haz1 = lookup(rs1, rs1_used);
    assign haz2 = lookup(rs2, rs2_used);
    assign hazw = lookup(rd, rd_we);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                logic fclr_hit;
                assign set_hit  = set_en  && (set_idx  == REG_ADDR_W'(gi));
                assign clr_hit  = clr_en  && (clr_idx  == REG_ADDR_W'(gi));
                assign fclr_hit = fclr_en && (fclr_idx == REG_ADDR_W'(gi));
                // A new producer claiming the register outranks any clear.
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit & ~fclr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_mask = busy_reg;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage between decode and execute: reads the register file, bypasses
// writeback data, stalls on RAW/WAW hazards and registers the operands.
module operand_fetch #(
    parameter int NUM_REGS = warp_pkg::NUM_REGS,
    parameter int XLEN     = warp_pkg::XLEN,
    parameter int CTRL_W   = warp_pkg::CTRL_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [warp_pkg::REG_ADDR_W-1:0] in_rs1,
    input  logic [warp_pkg::REG_ADDR_W-1:0] in_rs2,
    input  logic                            in_rs1_used,
    input  logic                            in_rs2_used,
    input  logic [warp_pkg::REG_ADDR_W-1:0] in_rd,
    input  logic                            in_rd_we,
    input  logic [XLEN-1:0]                 in_imm,
    input  logic [XLEN-1:0]                 in_pc,
    input  logic [CTRL_W-1:0]               in_ctrl,
    output logic [warp_pkg::REG_ADDR_W-1:0] rf_read_addr1,
    output logic [warp_pkg::REG_ADDR_W-1:0] rf_read_addr2,
    input  logic [XLEN-1:0]                 rf_read_data1,
    input  logic [XLEN-1:0]                 rf_read_data2,
    input  logic                            wb_valid,
    input  logic [warp_pkg::REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]                 wb_data,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [XLEN-1:0]                 out_rs1_data,
    output logic [XLEN-1:0]                 out_rs2_data,
    output logic [warp_pkg::REG_ADDR_W-1:0] out_rd,
    output logic                            out_rd_we,
    output logic [XLEN-1:0]                 out_imm,
    output logic [XLEN-1:0]                 out_pc,
    output logic [CTRL_W-1:0]               out_ctrl,
    output logic [NUM_REGS-1:0]             busy_mask
);

    import warp_pkg::*;

    logic            haz1;
    logic            haz2;
    logic            hazw;
    logic            accept;
    logic            set_en;
    logic            fclr_en;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;

    logic            valid_reg;
    issue_bundle_t   held_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;

    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;

    // Flush blocks intake so the killed slot cannot be refilled in the same cycle.
    assign in_ready = !flush && !(haz1 || haz2 || hazw) && (!valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    assign set_en  = accept && in_rd_we && (in_rd != '0);
    assign fclr_en = flush && valid_reg && held_reg.rd_we && (held_reg.rd != '0);

    warp_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_idx   (in_rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .fclr_en   (fclr_en),
        .fclr_idx  (held_reg.rd),
        .rs1       (in_rs1),
        .rs1_used  (in_rs1_used),
        .rs2       (in_rs2),
        .rs2_used  (in_rs2_used),
        .rd        (in_rd),
        .rd_we     (in_rd_we),
        .haz1      (haz1),
        .haz2      (haz2),
        .hazw      (hazw),
        .busy_mask (busy_mask)
    );

    // The RF returns the pre-write value, so a same-cycle writeback must be bypassed.
    assign rs1_sel = select_operand(in_rs1, in_rs1_used, rf_read_data1, wb_valid, wb_rd, wb_data);
    assign rs2_sel = select_operand(in_rs2, in_rs2_used, rf_read_data2, wb_valid, wb_rd, wb_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            held_reg     <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
        end else if (accept) begin
            valid_reg    <= 1'b1;
            held_reg     <= '{rd: in_rd, rd_we: in_rd_we, imm: in_imm, pc: in_pc, ctrl: in_ctrl};
            rs1_data_reg <= rs1_sel;
            rs2_data_reg <= rs2_sel;
        end else if (flush || out_ready) begin
            valid_reg    <= 1'b0;
        end
    end

    assign out_valid    = valid_reg;
    assign out_rs1_data = rs1_data_reg;
    assign out_rs2_data = rs2_data_reg;
    assign out_rd       = held_reg.rd;
    assign out_rd_we    = held_reg.rd_we;
    assign out_imm      = held_reg.imm;
    assign out_pc       = held_reg.pc;
    assign out_ctrl     = held_reg.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard-driven bench for operand_fetch: a reference busy/RF model predicts
// in_ready and the operand bundle of every accepted instruction.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_used, in_rs2_used, in_rd_we;
    logic [31:0] in_imm, in_pc;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_read_addr1, rf_read_addr2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_rs1_data, out_rs2_data, out_imm, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] out_ctrl;
    logic [31:0] busy_mask;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [15:0] ctrl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_busy;
    logic [31:0] rf_mem [32];
    logic [31:0] pc_ctr;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_read_data1 = rf_mem[rf_read_addr1];
    assign rf_read_data2 = rf_mem[rf_read_addr2];

    operand_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rs1_used   (in_rs1_used),
        .in_rs2_used   (in_rs2_used),
        .in_rd         (in_rd),
        .in_rd_we      (in_rd_we),
        .in_imm        (in_imm),
        .in_pc         (in_pc),
        .in_ctrl       (in_ctrl),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rs1_data  (out_rs1_data),
        .out_rs2_data  (out_rs2_data),
        .out_rd        (out_rd),
        .out_rd_we     (out_rd_we),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_ctrl      (out_ctrl),
        .busy_mask     (busy_mask)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic haz(input logic [4:0] r, input logic u);
        return u && (r != 5'd0) && m_busy[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic u);
        if (!u || r == 5'd0) return 32'd0;
        if (wb_valid && wb_rd == r) return wb_data;
        return rf_mem[r];
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic we);
        in_valid    = v;
        in_rs1      = rs1;
        in_rs1_used = u1;
        in_rs2      = rs2;
        in_rs2_used = u2;
        in_rd       = rd;
        in_rd_we    = we;
        pc_ctr      = pc_ctr + 32'd4;
        in_pc       = pc_ctr;
        in_imm      = $urandom;
        in_ctrl     = 16'($urandom);
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    // One clock: predict, compare, advance the model across the edge.
    task automatic cycle();
        logic        held, exp_ready, acc;
        logic [31:0] nb;
        exp_t        e;
        #1;
        held      = (q.size() != 0);
        exp_ready = !flush && !(haz(in_rs1, in_rs1_used) || haz(in_rs2, in_rs2_used) ||
                                haz(in_rd, in_rd_we)) && (!held || out_ready);
        acc       = in_valid && exp_ready;
        check_val("in_ready", in_ready, exp_ready);
        check_val("out_valid", out_valid, held);
        check_val("busy_mask", busy_mask, m_busy);
        check_val("rf_addr1", rf_read_addr1, in_rs1);
        check_val("rf_addr2", rf_read_addr2, in_rs2);
        nb = m_busy;
        if (wb_valid) nb[wb_rd] = 1'b0;
        if (held) begin
            e = q[0];
            check_val("out_rs1_data", out_rs1_data, e.a);
            check_val("out_rs2_data", out_rs2_data, e.b);
            check_val("out_rd", out_rd, e.rd);
            check_val("out_rd_we", out_rd_we, e.we);
            check_val("out_imm", out_imm, e.imm);
            check_val("out_pc", out_pc, e.pc);
            check_val("out_ctrl", out_ctrl, e.ctrl);
            if (flush) begin
                if (e.we && e.rd != 5'd0) nb[e.rd] = 1'b0;
                void'(q.pop_front());
                $display("flush pc=%h rd=%0d", e.pc, e.rd);
            end else if (out_ready) begin
                void'(q.pop_front());
                $display("xfer  pc=%h rs1=%h rs2=%h rd=%0d we=%0d", e.pc, e.a, e.b, e.rd, e.we);
            end
        end
        if (acc) begin
            e.a    = opnd(in_rs1, in_rs1_used);
            e.b    = opnd(in_rs2, in_rs2_used);
            e.rd   = in_rd;
            e.we   = in_rd_we;
            e.imm  = in_imm;
            e.pc   = in_pc;
            e.ctrl = in_ctrl;
            q.push_back(e);
            if (in_rd_we && in_rd != 5'd0) nb[in_rd] = 1'b1;
        end
        nb[0] = 1'b0;
        @(posedge clk);
        m_busy = nb;
        if (wb_valid && wb_rd != 5'd0) rf_mem[wb_rd] = wb_data;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        pc_ctr = 32'h1000;
        m_busy = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEADBEEF;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_busy", busy_mask, 32'd0);
        check_val("reset_out_pc", out_pc, 32'd0);
        rst = 1'b0;

        // RAW stall on rd=5, released by a same-cycle writeback bypass
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        cycle();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle();
        cycle();
        set_wb(1'b1, 5'd5, 32'hCAFEF00D);
        cycle();
        set_wb(1'b0, 5'd0, 32'd0);
        check_val("t2_bypass", out_rs1_data, 32'hCAFEF00D);

        // R0 reads as zero even when the RF drives garbage; rd=0 never busy
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        cycle();
        check_val("t3_rs1_zero", out_rs1_data, 32'd0);
        check_val("t3_busy_zero", busy_mask, 32'd0);

        // Backpressure: held output stays stable, then streams one per cycle
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1);
        cycle();
        drive(1'b1, 5'd20, 1'b1, 5'd21, 1'b1, 5'd9, 1'b1);
        repeat (3) cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            drive(1'b1, 5'd22, 1'b1, 5'd23, 1'b1, 5'(10 + i), 1'b1);
        end
        cycle();

        // Flush of held rd=7 releases its busy bit
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_val("t5_out_valid", out_valid, 1'b0);
        check_val("t5_busy7", busy_mask[7], 1'b0);

        // WAW on rd=3; set wins over a same-cycle writeback clear
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cycle();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cycle();
        set_wb(1'b1, 5'd3, 32'h33333333);
        cycle();
        set_wb(1'b0, 5'd0, 32'd0);
        check_val("t6_busy3", busy_mask[3], 1'b1);

        // Asynchronous reset with an instruction held in the output stage
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        cycle();
        check_val("t1_pre_valid", out_valid, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        #1;
        check_val("t1_out_valid", out_valid, 1'b0);
        check_val("t1_busy", busy_mask, 32'd0);
        check_val("t1_in_ready", in_ready, 1'b1);
        check_val("t1_out_rs1", out_rs1_data, 32'd0);
        q.delete();
        m_busy = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom));
            set_wb(1'($urandom), 5'($urandom), $urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        check_val("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
